// File: rtl/reg_display_scanner_pkg.sv
// Shared constants for the register-value display scanner:
// hex-to-segment table, blanking values and digit-state encoding.
package reg_display_scanner_pkg;

  // Active-low "everything dark" values for the segment and anode buses.
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns, entry n lights hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Which digit is currently being driven; D0 is the rightmost digit.
  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } digit_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/reg_display_scanner_button_debouncer.sv
// Raw push-button conditioning: 2-FF synchroniser, stable-level debounce,
// and a one-cycle press pulse on each accepted 0->1 transition.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has differed from the stable level long enough.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    pulse_d = stable_d & ~stable_q;
  end

  // Synchroniser, debounce state and press-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign press = pulse_q;

endmodule

// File: rtl/reg_display_scanner.sv
// Steps a 5-bit debug index (buttons or auto-advance) and shows the returned
// 16-bit value as four hex digits on a multiplexed 7-segment display.
module reg_display_scanner
  import reg_display_scanner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000,
  parameter int AUTO_CYCLES     = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        auto_en,
  input  logic [15:0] number,
  output logic [4:0]  index,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [AW-1:0] AUTO_LAST    = AW'(AUTO_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  logic          next_pulse, prev_pulse;
  logic          auto_sync1_q, auto_sync2_q;
  logic [4:0]    index_q, index_d;
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  digit_state_t  state_q;
  logic [RW-1:0] refresh_cnt_q;
  logic [15:0]   latch_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic [1:0]    digit_sel;
  logic [3:0]    digit_nib;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_next),
    .press   (next_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_prev),
    .press   (prev_pulse)
  );

  // Next index: button presses win over auto-advance and restart the auto interval.
  always_comb begin
    index_d    = index_q;
    auto_cnt_d = '0;
    if (next_pulse && prev_pulse) begin
      auto_cnt_d = '0;
    end else if (next_pulse) begin
      index_d = index_q + 5'd1;
    end else if (prev_pulse) begin
      index_d = index_q - 5'd1;
    end else if (auto_sync2_q) begin
      if (auto_cnt_q == AUTO_LAST) begin
        index_d = index_q + 5'd1;
      end else begin
        auto_cnt_d = auto_cnt_q + AW'(1);
      end
    end
  end

  // auto_en synchroniser, index and auto-advance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_sync1_q <= 1'b0;
      auto_sync2_q <= 1'b0;
      index_q      <= '0;
      auto_cnt_q   <= '0;
    end else begin
      auto_sync1_q <= auto_en;
      auto_sync2_q <= auto_sync1_q;
      index_q      <= index_d;
      auto_cnt_q   <= auto_cnt_d;
    end
  end

  assign digit_sel = state_q;
  assign digit_nib = latch_q[{digit_sel, 2'b00} +: 4];

  // Digit scan FSM; anode and segment are registered together from the same state
  // and latch, and the latch only reloads on entry to D0 so a frame is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= D0;
      refresh_cnt_q <= '0;
      latch_q       <= '0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
    end else begin
      an_q  <= ~(4'b0001 << digit_sel);
      seg_q <= hex_to_seg(digit_nib);
      if (refresh_cnt_q == REFRESH_LAST) begin
        refresh_cnt_q <= '0;
        state_q       <= digit_state_t'(digit_sel + 2'd1);
        if (state_q == D3) begin
          latch_q <= number;
        end
      end else begin
        refresh_cnt_q <= refresh_cnt_q + RW'(1);
      end
    end
  end

  assign index = index_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = 1'b1;

endmodule
